// File: rtl/match_pkg.sv
// match_pkg: shared encodings for the rock-paper-scissors match judge.
// Move codes, result codes, FSM state codes, LFSR tap mask and the judge rule.
package match_pkg;

    // Move encoding (player and CPU share it)
    localparam logic [1:0] MOVE_NONE     = 2'b00;
    localparam logic [1:0] MOVE_ROCK     = 2'b01;
    localparam logic [1:0] MOVE_PAPER    = 2'b10;
    localparam logic [1:0] MOVE_SCISSORS = 2'b11;

    // Result encoding, from the player's point of view
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_DRAW = 2'b01;
    localparam logic [1:0] RES_WIN  = 2'b10;
    localparam logic [1:0] RES_LOSE = 2'b11;

    // FSM state codes
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_REVEAL = 2'b01;
    localparam logic [1:0] ST_RESULT = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

    // Feedback taps q7, q5, q4, q3 of the move LFSR
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Rock beats scissors, paper beats rock, scissors beats paper
    function automatic logic [1:0] judge_moves(input logic [1:0] player, input logic [1:0] cpu);
        logic [1:0] res;
        if (player == cpu) begin
            res = RES_DRAW;
        end else if ((player == MOVE_ROCK     && cpu == MOVE_SCISSORS) ||
                     (player == MOVE_PAPER    && cpu == MOVE_ROCK)     ||
                     (player == MOVE_SCISSORS && cpu == MOVE_PAPER)) begin
            res = RES_WIN;
        end else begin
            res = RES_LOSE;
        end
        return res;
    endfunction

endpackage

// File: rtl/match_lfsr.sv
// match_lfsr: 8-bit left-shifting Fibonacci LFSR used to draw the CPU move.
// Runs whenever i_en is high; reset loads SEED (must be nonzero).
module match_lfsr
    import match_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_en,
    output logic [7:0] o_state
);

    logic [7:0] r_state;
    logic       w_feedback;

    assign w_feedback = ^(r_state & LFSR_TAPS);

    // Shift left, feeding the tap parity into bit 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= {r_state[6:0], w_feedback};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/match_judge.sv
// match_judge: accepts a player move, draws a CPU move, shows it for REVEAL_CYCLES,
// then emits a one-cycle matchresult pulse. Stops in DONE after MAX_ROUNDS rounds.
// Optional feature macro: DRAW_REPLAY_EN (draws are replayed instead of counted,
// signalled on the extra `replay` output).
//
// Handshake: player_valid is a qualifier, not a valid/ready pair. A move is taken
// only in IDLE when player_valid=1 and player_move!=00; at all other times the input
// is dropped. matchresult (and replay) is a single-cycle strobe with no back-pressure.
module match_judge
    import match_pkg::*;
#(
    parameter int         REVEAL_CYCLES = 16,
    parameter int         MAX_ROUNDS    = 9,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       player_valid,
    input  logic [1:0] player_move,
    output logic [1:0] matchresult,
    output logic [1:0] cpu_move,
    output logic       reveal,
    output logic       busy,
    output logic       done,
`ifdef DRAW_REPLAY_EN
    output logic       replay,
`endif
    output logic [1:0] dbg_state,
    output logic [3:0] dbg_round_cnt,
    output logic [7:0] dbg_lfsr
);

    logic [1:0] r_state;
    logic [7:0] r_rev_cnt;
    logic [3:0] r_round_cnt;
    logic [1:0] r_player;
    logic [1:0] r_cpu;
    logic [1:0] r_result;
    logic       r_replay;

    logic [7:0] w_lfsr;
    logic [1:0] w_cpu_pick;
    logic       w_accept;
    logic       w_reveal_end;
    logic [1:0] w_judge;
    logic [1:0] w_result_code;
    logic       w_replay_code;
    logic [3:0] w_round_next;
    logic       w_last_round;
`ifdef DRAW_REPLAY_EN
    logic       w_is_draw;
`endif

    match_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .resetn  (resetn),
        .i_en    (1'b1),
        .o_state (w_lfsr)
    );

    // A zero LFSR pair would be an invalid move, so it is folded onto rock
    assign w_cpu_pick   = (w_lfsr[1:0] == MOVE_NONE) ? MOVE_ROCK : w_lfsr[1:0];
    assign w_accept     = (r_state == ST_IDLE) && player_valid && (player_move != MOVE_NONE);
    assign w_reveal_end = (r_state == ST_REVEAL) && (r_rev_cnt == 8'd0);
    assign w_judge      = judge_moves(r_player, r_cpu);
    assign w_round_next = r_round_cnt + 4'd1;
    assign w_last_round = (w_round_next == 4'(MAX_ROUNDS));

`ifdef DRAW_REPLAY_EN
    assign w_is_draw     = (r_player == r_cpu);
    assign w_result_code = w_is_draw ? RES_NONE : w_judge;
    assign w_replay_code = w_is_draw;
`else
    assign w_result_code = w_judge;
    assign w_replay_code = 1'b0;
`endif

    // Round FSM: move latch, reveal countdown and round counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_rev_cnt   <= 8'd0;
            r_round_cnt <= 4'd0;
            r_player    <= MOVE_NONE;
            r_cpu       <= MOVE_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_player  <= player_move;
                        r_cpu     <= w_cpu_pick;
                        r_rev_cnt <= 8'(REVEAL_CYCLES - 1);
                        r_state   <= ST_REVEAL;
                    end
                end
                ST_REVEAL: begin
                    if (r_rev_cnt == 8'd0) begin
                        r_state <= ST_RESULT;
                    end else begin
                        r_rev_cnt <= r_rev_cnt - 8'd1;
                    end
                end
                ST_RESULT: begin
`ifdef DRAW_REPLAY_EN
                    if (w_is_draw) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_round_cnt <= w_round_next;
                        r_state     <= w_last_round ? ST_DONE : ST_IDLE;
                    end
`else
                    r_round_cnt <= w_round_next;
                    r_state     <= w_last_round ? ST_DONE : ST_IDLE;
`endif
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result strobe registered on entry to RESULT, so it is high exactly in that cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_result <= RES_NONE;
            r_replay <= 1'b0;
        end else if (w_reveal_end) begin
            r_result <= w_result_code;
            r_replay <= w_replay_code;
        end else begin
            r_result <= RES_NONE;
            r_replay <= 1'b0;
        end
    end

    assign matchresult   = r_result;
    assign cpu_move      = r_cpu;
    assign reveal        = (r_state == ST_REVEAL);
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
    assign dbg_state     = r_state;
    assign dbg_round_cnt = r_round_cnt;
    assign dbg_lfsr      = w_lfsr;

`ifdef DRAW_REPLAY_EN
    assign replay = r_replay;
`else
    // Replay strobe has no port in this build; keep it referenced
    logic w_replay_unused;
    assign w_replay_unused = r_replay;
`endif

endmodule

// File: tb/tb_match_judge.sv
// tb_match_judge: directed and random rounds of match_judge checked every cycle
// against a round-level reference model (accept cycle + fixed latency arithmetic).
`timescale 1ns/1ps
module tb_match_judge;

    localparam int         R    = 4;
    localparam int         MAXR = 3;
    localparam logic [7:0] SEED = 8'hA5;
    localparam int         NEVER = 1 << 30;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       player_valid = 1'b0;
    logic [1:0] player_move = 2'b00;
    logic [1:0] matchresult;
    logic [1:0] cpu_move;
    logic       reveal;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;
    logic [3:0] dbg_round_cnt;
    logic [7:0] dbg_lfsr;
    logic       obs_replay;

    always #5 clk = ~clk;

`ifdef DRAW_REPLAY_EN
    logic replay;
    assign obs_replay = replay;
    localparam bit REPLAY_BUILD = 1'b1;
`else
    assign obs_replay = 1'b0;
    localparam bit REPLAY_BUILD = 1'b0;
`endif

    match_judge #(
        .REVEAL_CYCLES (R),
        .MAX_ROUNDS    (MAXR),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .player_valid  (player_valid),
        .player_move   (player_move),
        .matchresult   (matchresult),
        .cpu_move      (cpu_move),
        .reveal        (reveal),
        .busy          (busy),
        .done          (done),
`ifdef DRAW_REPLAY_EN
        .replay        (replay),
`endif
        .dbg_state     (dbg_state),
        .dbg_round_cnt (dbg_round_cnt),
        .dbg_lfsr      (dbg_lfsr)
    );

    int n_pass   = 0;
    int n_checks = 0;

    // Reference model: one round is described by its accept cycle only
    int         cyc = 0;
    logic [7:0] m_lfsr = SEED;
    bit         m_pending = 1'b0;
    int         m_acc = 0;
    int         m_res_cyc = 0;
    logic [1:0] m_code = 2'b00;
    bit         m_replay = 1'b0;
    logic [1:0] m_cpu = 2'b00;
    int         m_rounds = 0;
    int         m_rounds_after = 0;
    int         m_done_cyc = NEVER;
    int         obs_pulses = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [1:0] cpu_pick(input logic [7:0] v);
        logic [1:0] lo;
        lo = v[1:0];
        return (lo == 2'b00) ? 2'b01 : lo;
    endfunction

    function automatic bit model_idle();
        return !(m_pending && cyc <= m_res_cyc) && (cyc < m_done_cyc);
    endfunction

    // One clock cycle: check outputs of this cycle, apply inputs to the model, advance
    task automatic tick(input logic v, input logic [1:0] mv);
        int d;
        logic       e_reveal, e_busy, e_done, e_rep;
        logic [1:0] e_res;
        player_valid = v;
        player_move  = mv;
        if (m_pending && cyc > m_res_cyc) begin
            m_rounds  = m_rounds_after;
            m_pending = 1'b0;
        end
        e_done   = (cyc >= m_done_cyc);
        e_reveal = m_pending && (cyc > m_acc) && (cyc <= m_acc + R);
        e_res    = (m_pending && cyc == m_res_cyc) ? m_code : 2'b00;
        e_rep    = m_pending && (cyc == m_res_cyc) && m_replay;
        e_busy   = m_pending || e_done;
        check("matchresult", {6'd0, matchresult}, {6'd0, e_res});
        check("flags", {4'd0, busy, reveal, done, obs_replay}, {4'd0, e_busy, e_reveal, e_done, e_rep});
        check("cpu_move", {6'd0, cpu_move}, {6'd0, m_cpu});
        check("round_cnt", {4'd0, dbg_round_cnt}, 8'(m_rounds));
        check("lfsr", dbg_lfsr, m_lfsr);
        if (matchresult != 2'b00 || obs_replay) obs_pulses++;
        if (model_idle() && v && mv != 2'b00) begin
            m_pending = 1'b1;
            m_acc     = cyc;
            m_res_cyc = cyc + R + 1;
            m_cpu     = cpu_pick(m_lfsr);
            d = (int'(mv) - int'(m_cpu) + 3) % 3;
            m_replay       = 1'b0;
            m_rounds_after = m_rounds + 1;
            if (d == 0) begin
                if (REPLAY_BUILD) begin
                    m_code         = 2'b00;
                    m_replay       = 1'b1;
                    m_rounds_after = m_rounds;
                end else begin
                    m_code = 2'b01;
                end
            end else if (d == 1) begin
                m_code = 2'b10;
            end else begin
                m_code = 2'b11;
            end
            if (m_rounds_after == MAXR && m_rounds_after != m_rounds) m_done_cyc = m_res_cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    // Asynchronous reset pulse: outputs must clear before any clock edge
    task automatic do_reset();
        resetn = 1'b0;
        #1;
        check("rst_matchresult", {6'd0, matchresult}, 8'd0);
        check("rst_flags", {4'd0, busy, reveal, done, obs_replay}, 8'd0);
        check("rst_cpu_move", {6'd0, cpu_move}, 8'd0);
        check("rst_state", {4'd0, dbg_round_cnt}, 8'd0);
        check("rst_lfsr", dbg_lfsr, SEED);
        m_pending  = 1'b0;
        m_rounds   = 0;
        m_cpu      = 2'b00;
        m_done_cyc = NEVER;
        m_lfsr     = SEED;
        player_valid = 1'b0;
        player_move  = 2'b00;
        repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        resetn = 1'b1;
    endtask

    // Idle until the model says the CPU would draw `target`, then submit `pmove`
    task automatic play_forced(input logic [1:0] pmove, input logic [1:0] target);
        bit found;
        int start;
        found = 1'b0;
        if (cyc >= m_done_cyc) do_reset();
        for (int k = 0; k < 64 && !found; k++) begin
            if (model_idle() && cpu_pick(m_lfsr) == target) found = 1'b1;
            else tick(1'b0, 2'b00);
        end
        check("wait_cpu_bound", {7'd0, found}, 8'd1);
        start = obs_pulses;
        tick(1'b1, pmove);
        for (int k = 0; k < R + 1; k++) tick(1'b0, 2'b00);
        check("one_pulse", 8'(obs_pulses - start), 8'd1);
    endtask

    initial begin
        bit         found;
        int         start;

        // 1: first accept after reset uses the seed: cpu=01, draw, pulse R+1 later
        #1;
        do_reset();
        tick(1'b1, 2'b01);
        check("t1_cpu", {6'd0, cpu_move}, 8'd1);
        for (int k = 0; k < R; k++) tick(1'b0, 2'b00);
        check("t1_result", {6'd0, matchresult, 1'b0, obs_replay},
              REPLAY_BUILD ? 8'b0000_0001 : 8'b0000_0100);
        tick(1'b0, 2'b00);

        // 2: all nine move pairs
        for (int p = 1; p <= 3; p++)
            for (int c = 1; c <= 3; c++)
                play_forced(2'(p), 2'(c));

        // 3: invalid move ignored; pulses during REVEAL ignored
        do_reset();
        for (int k = 0; k < 3; k++) tick(1'b1, 2'b00);
        check("t3_busy", {7'd0, busy}, 8'd0);
        tick(1'b1, 2'b10);
        for (int k = 0; k < R; k++) tick(1'b1, 2'($urandom_range(1, 3)));
        for (int k = 0; k < 3; k++) tick(1'b0, 2'b00);
        // held valid: one submission per IDLE visit
        for (int k = 0; k < 3 * (R + 2); k++) tick(1'b1, 2'b11);

        // 4: play until DONE, then extra pulses produce nothing
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            tick(1'b1, 2'($urandom_range(1, 3)));
            if (cyc > m_done_cyc) found = 1'b1;
        end
        check("t4_done_bound", {7'd0, found}, 8'd1);
        check("t4_done", {7'd0, done}, 8'd1);
        start = obs_pulses;
        for (int k = 0; k < 10; k++) tick(1'b1, 2'($urandom_range(1, 3)));
        check("t4_no_pulse", 8'(obs_pulses - start), 8'd0);

        // 5: reset in the middle of REVEAL
        do_reset();
        tick(1'b1, 2'b01);
        tick(1'b0, 2'b00);
        check("t5_reveal", {7'd0, reveal}, 8'd1);
        start = obs_pulses;
        do_reset();
        for (int k = 0; k < R + 3; k++) tick(1'b0, 2'b00);
        check("t5_no_pulse", 8'(obs_pulses - start), 8'd0);

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            if (cyc >= m_done_cyc || $urandom_range(0, 149) == 0) do_reset();
            else tick($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
